// File: rtl/tlv5618_pkg.sv
// Shared constants for the TLV5618 serial frame receiver: register-select codes,
// frame length, field bit positions and FSM state encoding.
package tlv5618_pkg;

  localparam logic [1:0] R_WR_B_BUF   = 2'b00;
  localparam logic [1:0] R_WR_BUF     = 2'b01;
  localparam logic [1:0] R_WR_A_UPD_B = 2'b10;
  localparam logic [1:0] R_RSVD       = 2'b11;

  localparam int FRAME_BITS = 16;

  localparam int BIT_R1    = 15;
  localparam int BIT_SPD   = 14;
  localparam int BIT_PWR   = 13;
  localparam int BIT_R0    = 12;
  localparam int BIT_D_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE
  } state_t;

endpackage

// File: rtl/tlv5618_frame_rx_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input, followed by a history flop
// so the level and its rise/fall strobes are all aligned to the same clk cycle.
module sync_edge_det #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // INIT lets an idle-high line (cs) come out of reset without a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{INIT}};
      r_hist <= INIT;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = ~r_hist &  r_sync[STAGES-1];
  assign o_fall  =  r_hist & ~r_sync[STAGES-1];

endmodule

// File: rtl/tlv5618_frame_rx.sv
// TLV5618 3-wire frame receiver: oversamples cs/sclk/din, deserialises MSB-first
// frames and mirrors the DAC A, DAC B and double-buffer registers.
module tlv5618_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = tlv5618_pkg::FRAME_BITS,
  parameter int DATA_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tlv_sclk,
  input  logic              tlv_din,
  input  logic              tlv_cs,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic [DATA_W-1:0] buf_q,
  output logic              speed,
  output logic              pwr_down,
  output logic [15:0]       frame_word,
  output logic              frame_valid,
  output logic              frame_err
);
  import tlv5618_pkg::*;

  logic w_sclk_fall, w_cs_level, w_cs_rise, w_cs_fall, w_din_s;
  logic w_unused_sclk_level, w_unused_sclk_rise, w_unused_din_rise, w_unused_din_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(tlv_sclk),
    .o_level(w_unused_sclk_level), .o_rise(w_unused_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(tlv_cs),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .i_async(tlv_din),
    .o_level(w_din_s), .o_rise(w_unused_din_rise), .o_fall(w_unused_din_fall)
  );

  state_t            r_state, w_next;
  logic [15:0]       r_sr;
  logic [4:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_dac_a, r_dac_b, r_buf_q;
  logic              r_speed, r_pwr_down, r_frame_valid, r_frame_err;
  logic [15:0]       r_frame_word;
  logic [1:0]        w_rsel;

  assign w_rsel = {r_sr[BIT_R1], r_sr[BIT_R0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_next = ST_SHIFT;
      ST_SHIFT:  if (w_cs_rise) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // The bit counter saturates so an overlong frame can never wrap back to a valid count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_dac_a       <= '0;
      r_dac_b       <= '0;
      r_buf_q       <= '0;
      r_speed       <= 1'b0;
      r_pwr_down    <= 1'b0;
      r_frame_word  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_sclk_fall && !w_cs_level) begin
            r_sr      <= {r_sr[14:0], w_din_s};
            r_bit_cnt <= (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;
          end
        end
        ST_DECODE: begin
          if (r_bit_cnt != 5'(FRAME_BITS)) begin
            r_frame_err <= 1'b1;
          end else begin
            r_frame_word <= r_sr;
            if (w_rsel == R_RSVD) begin
              r_frame_err <= 1'b1;
            end else begin
              r_speed       <= r_sr[BIT_SPD];
              r_pwr_down    <= r_sr[BIT_PWR];
              r_frame_valid <= 1'b1;
              case (w_rsel)
                R_WR_B_BUF: begin
                  r_dac_b <= r_sr[DATA_W-1:0];
                  r_buf_q <= r_sr[DATA_W-1:0];
                end
                R_WR_BUF: r_buf_q <= r_sr[DATA_W-1:0];
                R_WR_A_UPD_B: begin
                  r_dac_a <= r_sr[DATA_W-1:0];
                  r_dac_b <= r_buf_q;
                end
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dac_a       = r_dac_a;
  assign dac_b       = r_dac_b;
  assign buf_q       = r_buf_q;
  assign speed       = r_speed;
  assign pwr_down    = r_pwr_down;
  assign frame_word  = r_frame_word;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;

endmodule
